serial_out_arbiter: RTL and testbench

//   Shares the single bit-serial output channel (pin/en/co file sink) between N

---
 rtl/serial_out_arbiter_pkg.sv | 14 +
 rtl/serial_out_arbiter_rr_arbiter.sv | 32 +++
 rtl/serial_out_arbiter.sv | 100 ++++++++++
 tb/tb_serial_out_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_out_arbiter_pkg.sv
// rtl/serial_out_arbiter_pkg.sv - shared state encoding and width helper for the serial output arbiter
package serial_out_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Index/counter width; never narrower than one bit so degenerate sizes still elaborate
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/serial_out_arbiter_rr_arbiter.sv
// rtl/serial_out_arbiter_rr_arbiter.sv - combinational round-robin pick starting at the pointer lane
module rr_arbiter
  import serial_out_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = idx;
      end
    end
  end

endmodule

// File: rtl/serial_out_arbiter.sv
// rtl/serial_out_arbiter.sv - round-robin lane grant, W-bit capture and bit-serial shift-out with co on last bit
module serial_out_arbiter
  import serial_out_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 25,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              req_valid,
  input  logic [N*W-1:0]            req_data,
  output logic [N-1:0]              req_ready,
  input  logic                      hold,
  output logic                      out_en,
  output logic                      out_bit,
  output logic                      out_co,
  output logic [clog2_min1(N)-1:0]  grant_id,
  output logic                      busy
);

  localparam int CNT_W = clog2_min1(W);
  localparam int ID_W  = clog2_min1(N);

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gid_q, gid_d;

  logic [N-1:0]    arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic            shifting, last, accept;
  logic [W-1:0]    win_word;

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign win_word = req_data[int'(arb_idx)*W +: W];

  always_comb begin
    shifting = (state_q == ST_SHIFT) && !hold;
    last     = shifting && (cnt_q == CNT_W'(W - 1));
    // Reset gates acceptance so no ready pulse escapes while rst is held low
    accept   = rst && arb_any && ((state_q == ST_IDLE) || last);

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;

    if (shifting) begin
      shift_d = (MSB_FIRST != 0) ? {shift_q[W-2:0], 1'b0} : {1'b0, shift_q[W-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (last) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    // Accept on the last-bit cycle overrides the IDLE return: zero-bubble back-to-back
    if (accept) begin
      state_d = ST_SHIFT;
      shift_d = win_word;
      cnt_d   = '0;
      gid_d   = arb_idx;
      ptr_d   = (arb_idx == ID_W'(N - 1)) ? '0 : arb_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

  assign req_ready = accept ? arb_grant : '0;
  assign out_en    = shifting;
  assign out_bit   = (MSB_FIRST != 0) ? shift_q[W-1] : shift_q[0];
  assign out_co    = last;
  assign grant_id  = gid_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_out_arbiter.sv
// tb/tb_serial_out_arbiter.sv - scenario tasks plus randomized scoreboard run for serial_out_arbiter
module tb_serial_out_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  valid1 = '0, ready1, valid2 = '0, ready2;
  logic [31:0] data1 = '0, data2 = '0;
  logic        hold1 = 1'b0, hold2 = 1'b0;
  logic        en1, bit1, co1, busy1, en2, bit2, co2, busy2;
  logic [1:0]  gid1, gid2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  serial_out_arbiter #(.N(4), .W(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_data(data1), .req_ready(ready1),
    .hold(hold1), .out_en(en1), .out_bit(bit1), .out_co(co1), .grant_id(gid1), .busy(busy1)
  );

  serial_out_arbiter #(.N(4), .W(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_data(data2), .req_ready(ready2),
    .hold(hold2), .out_en(en2), .out_bit(bit2), .out_co(co2), .grant_id(gid2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; valid1 = '0; valid2 = '0; hold1 = 1'b0; hold2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; valid1 = 4'b1111; data1 = $urandom;
    @(negedge clk);
    checks++;
    if ({ready1, en1, bit1, co1, gid1, busy1} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {ready1, en1, bit1, co1, gid1, busy1});
    end
    do_reset;
    @(negedge clk);
    checks++;
    if ({ready1, en1, co1, busy1} !== 7'b0) begin
      errors++; $display("FAIL reset_release got=%b exp=0", {ready1, en1, co1, busy1});
    end
  endtask

  task automatic test_single_word;
    do_reset;
    valid1 = 4'b0100; data1 = $urandom; data1[23:16] = 8'hA5;
    @(negedge clk);
    checks++;
    if (ready1 !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", ready1); end
    tick; valid1 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({en1, bit1, co1, gid1} !== {1'b1, 8'hA5 >> (8 - i) & 8'h01 ? 1'b1 : 1'b0, (i == 8), 2'd2}) begin
        errors++; $display("FAIL single_bit%0d got en=%b bit=%b co=%b gid=%0d", i, en1, bit1, co1, gid1);
      end
      tick;
    end
    @(negedge clk);
    checks++;
    if ({busy1, en1, co1} !== 3'b000) begin errors++; $display("FAIL single_idle got=%b exp=000", {busy1, en1, co1}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    do_reset;
    valid1 = 4'b1111; data1 = $urandom;
    @(negedge clk);
    checks++;
    if (ready1 !== 4'b0001) begin errors++; $display("FAIL b2b_first_ready got=%b exp=0001", ready1); end
    tick;
    for (int g = 0; g < 4; g++) begin
      w = data1[g*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        checks++;
        if ({en1, bit1, co1, gid1} !== {1'b1, w[7-b], (b == 7), 2'(g)}) begin
          errors++; $display("FAIL b2b_lane%0d_bit%0d got en=%b bit=%b co=%b gid=%0d exp bit=%b", g, b, en1, bit1, co1, gid1, w[7-b]);
        end
        checks++;
        if (ready1 !== ((b == 7) ? 4'(1 << ((g + 1) % 4)) : 4'b0)) begin
          errors++; $display("FAIL b2b_ready_lane%0d_bit%0d got=%b", g, b, ready1);
        end
        tick;
      end
    end
    valid1 = '0;
  endtask

  task automatic test_hold_mid;
    logic [7:0] w;
    do_reset;
    w = 8'($urandom); valid1 = 4'b0001; data1 = {24'h0, w};
    tick; valid1 = '0;
    for (int i = 1; i <= 11; i++) begin
      hold1 = (i >= 4 && i <= 6);
      @(negedge clk);
      checks++;
      if (hold1) begin
        if ({en1, co1, busy1} !== 3'b001) begin errors++; $display("FAIL hold_mid_cyc%0d got=%b exp=001", i, {en1, co1, busy1}); end
      end else if ({en1, bit1, co1} !== {1'b1, w[(i < 4) ? 8 - i : 11 - i], (i == 11)}) begin
        errors++; $display("FAIL hold_mid_cyc%0d got en=%b bit=%b co=%b", i, en1, bit1, co1);
      end
      tick;
    end
    hold1 = 1'b0;
  endtask

  task automatic test_hold_last;
    do_reset;
    valid1 = 4'b0001; data1 = $urandom;
    tick; valid1 = 4'b0010;
    for (int i = 1; i <= 9; i++) begin
      hold1 = (i == 8);
      @(negedge clk);
      checks++;
      if ({co1, ready1} !== ((i == 9) ? 5'b1_0010 : 5'b0)) begin
        errors++; $display("FAIL hold_last_cyc%0d got co=%b ready=%b", i, co1, ready1);
      end
      tick;
    end
    hold1 = 1'b0; valid1 = '0;
    @(negedge clk);
    checks++;
    if ({en1, gid1} !== 3'b1_01) begin errors++; $display("FAIL hold_last_next got en=%b gid=%0d exp en=1 gid=1", en1, gid1); end
  endtask

  task automatic test_async_reset;
    do_reset;
    valid1 = 4'b0100; data1 = 32'hFFFF_FFFF;
    tick; valid1 = '0;
    repeat (3) tick;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ready1, en1, co1, gid1, busy1} !== 9'b0) begin
      errors++; $display("FAIL async_reset got=%b exp=0", {ready1, en1, co1, gid1, busy1});
    end
    @(posedge clk); #1 rst = 1'b1;
    valid1 = 4'b1111;
    @(negedge clk);
    checks++;
    if (ready1 !== 4'b0001) begin errors++; $display("FAIL async_ptr_restart got=%b exp=0001", ready1); end
    tick; valid1 = '0;
  endtask

  task automatic test_lsb_first;
    do_reset;
    valid2 = 4'b0001; data2 = {24'h0, 8'h01};
    tick; valid2 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({en2, bit2, co2} !== {1'b1, (i == 1), (i == 8)}) begin
        errors++; $display("FAIL lsb_bit%0d got en=%b bit=%b co=%b", i, en2, bit2, co2);
      end
      tick;
    end
  endtask

  task automatic test_random;
    logic [3:0] q[$];
    logic [3:0] exp_rdy;
    logic [7:0] w;
    logic       co_e;
    int         ptr, win;
    do_reset;
    ptr = 0;
    for (int c = 0; c < 400; c++) begin
      valid1 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      data1  = $urandom;
      hold1  = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      co_e = (q.size() > 0) && !hold1 && q[0][1];
      win = -1;
      if ((q.size() == 0 || co_e) && valid1 != 0)
        for (int k = 0; k < 4; k++)
          if (win < 0 && valid1[(ptr + k) % 4]) win = (ptr + k) % 4;
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
      checks++;
      if (ready1 !== exp_rdy) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ready1, exp_rdy); end
      checks++;
      if ({busy1, en1} !== {q.size() > 0, q.size() > 0 && !hold1}) begin
        errors++; $display("FAIL rand_busy_en c=%0d got=%b", c, {busy1, en1});
      end
      if (q.size() > 0) begin
        checks++;
        if (gid1 !== q[0][3:2]) begin errors++; $display("FAIL rand_gid c=%0d got=%0d exp=%0d", c, gid1, q[0][3:2]); end
      end
      checks++;
      if (q.size() > 0 && !hold1) begin
        if ({bit1, co1} !== {q[0][0], q[0][1]}) begin
          errors++; $display("FAIL rand_bit c=%0d got bit=%b co=%b exp bit=%b co=%b", c, bit1, co1, q[0][0], q[0][1]);
        end
        void'(q.pop_front());
      end else if (co1 !== 1'b0) begin
        errors++; $display("FAIL rand_co_idle c=%0d got=%b exp=0", c, co1);
      end
      if (win >= 0) begin
        w = data1[win*8 +: 8];
        for (int b = 7; b >= 0; b--) q.push_back({2'(win), (b == 0), w[b]});
        ptr = (win + 1) % 4;
      end
      tick;
    end
    valid1 = '0; hold1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_hold_mid;
    test_hold_last;
    test_async_reset;
    test_lsb_first;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
